// File: rtl/axi_slave_ram_responder_if.sv
// axi_slave_ram_responder_if
//   AXI4 slave-side bus bundle of the lab bus (SLAVE_CLK domain).
//   Channels: write address (WR_ADDR_*), write data (WR_DATA_*), write response (WR_BACK_*),
//   read address (RD_ADDR_*), read data (RD_BACK_ID / RD_DATA_*).
//   Modports: master drives requests and response READYs; slave drives ADDR/DATA READYs and
//   response payloads.
interface axi_slave_ram_responder_if;
  logic [3:0]  SLAVE_WR_ADDR_ID;
  logic [31:0] SLAVE_WR_ADDR;
  logic [7:0]  SLAVE_WR_ADDR_LEN;
  logic [1:0]  SLAVE_WR_ADDR_BURST;
  logic        SLAVE_WR_ADDR_VALID;
  logic        SLAVE_WR_ADDR_READY;

  logic [31:0] SLAVE_WR_DATA;
  logic [3:0]  SLAVE_WR_STRB;
  logic        SLAVE_WR_DATA_LAST;
  logic        SLAVE_WR_DATA_VALID;
  logic        SLAVE_WR_DATA_READY;

  logic [3:0]  SLAVE_WR_BACK_ID;
  logic [1:0]  SLAVE_WR_BACK_RESP;
  logic        SLAVE_WR_BACK_VALID;
  logic        SLAVE_WR_BACK_READY;

  logic [3:0]  SLAVE_RD_ADDR_ID;
  logic [31:0] SLAVE_RD_ADDR;
  logic [7:0]  SLAVE_RD_ADDR_LEN;
  logic [1:0]  SLAVE_RD_ADDR_BURST;
  logic        SLAVE_RD_ADDR_VALID;
  logic        SLAVE_RD_ADDR_READY;

  logic [3:0]  SLAVE_RD_BACK_ID;
  logic [31:0] SLAVE_RD_DATA;
  logic [1:0]  SLAVE_RD_DATA_RESP;
  logic        SLAVE_RD_DATA_LAST;
  logic        SLAVE_RD_DATA_VALID;
  logic        SLAVE_RD_DATA_READY;

  modport master (
    output SLAVE_WR_ADDR_ID, SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
    output SLAVE_WR_ADDR_VALID,
    input  SLAVE_WR_ADDR_READY,
    output SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_WR_DATA_LAST, SLAVE_WR_DATA_VALID,
    input  SLAVE_WR_DATA_READY,
    input  SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID,
    output SLAVE_WR_BACK_READY,
    output SLAVE_RD_ADDR_ID, SLAVE_RD_ADDR, SLAVE_RD_ADDR_LEN, SLAVE_RD_ADDR_BURST,
    output SLAVE_RD_ADDR_VALID,
    input  SLAVE_RD_ADDR_READY,
    input  SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST,
    input  SLAVE_RD_DATA_VALID,
    output SLAVE_RD_DATA_READY
  );

  modport slave (
    input  SLAVE_WR_ADDR_ID, SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
    input  SLAVE_WR_ADDR_VALID,
    output SLAVE_WR_ADDR_READY,
    input  SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_WR_DATA_LAST, SLAVE_WR_DATA_VALID,
    output SLAVE_WR_DATA_READY,
    output SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID,
    input  SLAVE_WR_BACK_READY,
    input  SLAVE_RD_ADDR_ID, SLAVE_RD_ADDR, SLAVE_RD_ADDR_LEN, SLAVE_RD_ADDR_BURST,
    input  SLAVE_RD_ADDR_VALID,
    output SLAVE_RD_ADDR_READY,
    output SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST,
    output SLAVE_RD_DATA_VALID,
    input  SLAVE_RD_DATA_READY
  );
endinterface

// File: rtl/axi_slave_ram_responder.sv
// axi_slave_ram_responder
//   AXI4 slave endpoint backed by a word RAM of 2**MEM_DEPTH_LOG2 x 32 bits. Independent write
//   and read FSMs share the array; one burst outstanding per direction.
//   Ports: SLAVE_CLK (rising edge), SLAVE_RST (synchronous, active-high),
//          bus (axi_slave_ram_responder_if.slave), busy_flag = {write busy, read busy}.
//   Build option: define SLAVE_RAM_WRAP_BURST_EN to execute WRAP bursts; otherwise WRAP is
//   answered like the reserved burst type (SLVERR every beat, no writes, read data 0).
module axi_slave_ram_responder #(
  parameter int unsigned MEM_DEPTH_LOG2 = 8
) (
  input  logic                            SLAVE_CLK,
  input  logic                            SLAVE_RST,
  axi_slave_ram_responder_if.slave        bus,
  output logic [1:0]                      busy_flag
);
  localparam int unsigned Depth = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned IdxW  = MEM_DEPTH_LOG2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [31:0] mem [Depth];

  function automatic logic in_range(input logic [31:0] a);
    return a[31:IdxW+2] == '0;
  endfunction

  // Burst types that must not touch memory at all.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
`ifdef SLAVE_RAM_WRAP_BURST_EN
    if (burst == 2'b10) return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
    if (burst == 2'b10) return 1'b1;
`endif
    return burst == 2'b11;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic [31:0] mask;
    mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      2'b01:   return a + 32'd4;
      2'b10:   return (a & ~mask) | ((a + 32'd4) & mask);
      default: return a;
    endcase
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic bad);
    if (bad) return RespSlvErr;
    return in_range(a) ? RespOkay : RespDecErr;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    if (a == RespDecErr || b == RespDecErr) return RespDecErr;
    if (a == RespSlvErr || b == RespSlvErr) return RespSlvErr;
    return RespOkay;
  endfunction

  // ---------------- write path ----------------
  w_state_e    w_state_q;
  logic [3:0]  w_id_q;
  logic [31:0] w_addr_q;
  logic [7:0]  w_len_q;
  logic [1:0]  w_burst_q;
  logic        w_bad_q;
  logic [8:0]  w_cnt_q;
  logic [1:0]  w_resp_q;

  logic       w_last_beat;
  logic [1:0] w_beat_resp;
  logic       mem_we;

  assign w_last_beat = (w_cnt_q == {1'b0, w_len_q});

  always_comb begin
    w_beat_resp = beat_resp(w_addr_q, w_bad_q);
    // LAST must coincide exactly with the LEN-derived final beat.
    if (bus.SLAVE_WR_DATA_LAST != w_last_beat) w_beat_resp = worst(w_beat_resp, RespSlvErr);
  end

  assign mem_we = !SLAVE_RST && (w_state_q == WData) && bus.SLAVE_WR_DATA_VALID &&
                  !w_bad_q && in_range(w_addr_q);

  always_ff @(posedge SLAVE_CLK) begin
    if (SLAVE_RST) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_bad_q   <= 1'b0;
      w_cnt_q   <= '0;
      w_resp_q  <= RespOkay;
    end else begin
      unique case (w_state_q)
        WIdle: if (bus.SLAVE_WR_ADDR_VALID) begin
          w_id_q    <= bus.SLAVE_WR_ADDR_ID;
          w_addr_q  <= bus.SLAVE_WR_ADDR;
          w_len_q   <= bus.SLAVE_WR_ADDR_LEN;
          w_burst_q <= bus.SLAVE_WR_ADDR_BURST;
          w_bad_q   <= burst_bad(bus.SLAVE_WR_ADDR_BURST, bus.SLAVE_WR_ADDR_LEN);
          w_cnt_q   <= '0;
          w_resp_q  <= RespOkay;
          w_state_q <= WData;
        end
        WData: if (bus.SLAVE_WR_DATA_VALID) begin
          w_resp_q <= worst(w_resp_q, w_beat_resp);
          if (w_last_beat) begin
            w_state_q <= WResp;
          end else begin
            w_cnt_q  <= w_cnt_q + 9'd1;
            w_addr_q <= next_addr(w_addr_q, w_burst_q, w_len_q);
          end
        end
        WResp: if (bus.SLAVE_WR_BACK_READY) w_state_q <= WIdle;
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // RAM is intentionally not reset; a read in the same cycle sees the old word.
  always_ff @(posedge SLAVE_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.SLAVE_WR_STRB[b]) mem[w_addr_q[IdxW+1:2]][8*b +: 8] <= bus.SLAVE_WR_DATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e    r_state_q;
  logic [3:0]  r_id_q;
  logic [31:0] r_addr_q;
  logic [7:0]  r_len_q;
  logic [1:0]  r_burst_q;
  logic        r_bad_q;
  logic [8:0]  r_cnt_q;

  logic       r_last_beat;
  logic [1:0] r_beat_resp;
  logic       r_valid;

  assign r_last_beat = (r_cnt_q == {1'b0, r_len_q});
  assign r_beat_resp = beat_resp(r_addr_q, r_bad_q);
  assign r_valid     = !SLAVE_RST && (r_state_q == RData);

  always_ff @(posedge SLAVE_CLK) begin
    if (SLAVE_RST) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_bad_q   <= 1'b0;
      r_cnt_q   <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: if (bus.SLAVE_RD_ADDR_VALID) begin
          r_id_q    <= bus.SLAVE_RD_ADDR_ID;
          r_addr_q  <= bus.SLAVE_RD_ADDR;
          r_len_q   <= bus.SLAVE_RD_ADDR_LEN;
          r_burst_q <= bus.SLAVE_RD_ADDR_BURST;
          r_bad_q   <= burst_bad(bus.SLAVE_RD_ADDR_BURST, bus.SLAVE_RD_ADDR_LEN);
          r_cnt_q   <= '0;
          r_state_q <= RData;
        end
        RData: if (bus.SLAVE_RD_DATA_READY) begin
          if (r_last_beat) begin
            r_state_q <= RIdle;
          end else begin
            r_cnt_q  <= r_cnt_q + 9'd1;
            r_addr_q <= next_addr(r_addr_q, r_burst_q, r_len_q);
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // ---------------- outputs (forced to 0 while in reset) ----------------
  assign bus.SLAVE_WR_ADDR_READY = !SLAVE_RST && (w_state_q == WIdle);
  assign bus.SLAVE_WR_DATA_READY = !SLAVE_RST && (w_state_q == WData);
  assign bus.SLAVE_WR_BACK_VALID = !SLAVE_RST && (w_state_q == WResp);
  assign bus.SLAVE_WR_BACK_ID    = bus.SLAVE_WR_BACK_VALID ? w_id_q : '0;
  assign bus.SLAVE_WR_BACK_RESP  = bus.SLAVE_WR_BACK_VALID ? w_resp_q : RespOkay;

  assign bus.SLAVE_RD_ADDR_READY = !SLAVE_RST && (r_state_q == RIdle);
  assign bus.SLAVE_RD_DATA_VALID = r_valid;
  assign bus.SLAVE_RD_BACK_ID    = r_valid ? r_id_q : '0;
  assign bus.SLAVE_RD_DATA_RESP  = r_valid ? r_beat_resp : RespOkay;
  assign bus.SLAVE_RD_DATA_LAST  = r_valid && r_last_beat;
  assign bus.SLAVE_RD_DATA       = (r_valid && r_beat_resp == RespOkay) ?
                                   mem[r_addr_q[IdxW+1:2]] : '0;

  assign busy_flag = SLAVE_RST ? 2'b00 : {w_state_q != WIdle, r_state_q != RIdle};
endmodule

// File: tb/tb_axi_slave_ram_responder.sv
// Directed bench for axi_slave_ram_responder with a scoreboard of expected B responses and
// R beats. Expectations are pushed when stimulus is issued and popped as the DUT responds.
module tb_axi_slave_ram_responder;
  logic       SLAVE_CLK = 1'b0;
  logic       SLAVE_RST = 1'b1;
  logic [1:0] busy_flag;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [5:0] b_q[$];

  axi_slave_ram_responder_if bus ();

  axi_slave_ram_responder #(.MEM_DEPTH_LOG2(8)) dut (
    .SLAVE_CLK (SLAVE_CLK),
    .SLAVE_RST (SLAVE_RST),
    .bus       (bus),
    .busy_flag (busy_flag)
  );

  always #5 SLAVE_CLK = ~SLAVE_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge SLAVE_CLK);
    #1;
  endtask

  task automatic push_rd(input logic [31:0] data, input logic [1:0] resp, input logic last);
    rd_exp_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    rd_q.push_back(e);
  endtask

  task automatic push_seq(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) push_rd(d0 + 32'(i), 2'b00, i == n - 1);
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                           input int last_at, input logic [1:0] exp_resp, input int hold);
    int n;
    logic [5:0] e;
    b_q.push_back({id, exp_resp});
    bus.SLAVE_WR_ADDR_ID    = id;
    bus.SLAVE_WR_ADDR       = addr;
    bus.SLAVE_WR_ADDR_LEN   = len;
    bus.SLAVE_WR_ADDR_BURST = burst;
    bus.SLAVE_WR_ADDR_VALID = 1'b1;
    n = 0;
    while (bus.SLAVE_WR_ADDR_READY !== 1'b1 && n < 50) begin tick(); n++; end
    check("aw_wait", 32'(n < 50), 1);
    tick();
    bus.SLAVE_WR_ADDR_VALID = 1'b0;
    check("w_ready_after_aw", 32'(bus.SLAVE_WR_DATA_READY), 1);
    check("aw_ready_busy", 32'(bus.SLAVE_WR_ADDR_READY), 0);
    for (int i = 0; i <= int'(len); i++) begin
      bus.SLAVE_WR_DATA       = d0 + 32'(i);
      bus.SLAVE_WR_STRB       = strb;
      bus.SLAVE_WR_DATA_LAST  = (i == last_at);
      bus.SLAVE_WR_DATA_VALID = 1'b1;
      n = 0;
      while (bus.SLAVE_WR_DATA_READY !== 1'b1 && n < 50) begin tick(); n++; end
      check("w_wait", 32'(n < 50), 1);
      tick();
    end
    bus.SLAVE_WR_DATA_VALID = 1'b0;
    bus.SLAVE_WR_DATA_LAST  = 1'b0;
    check("b_valid_after_last", 32'(bus.SLAVE_WR_BACK_VALID), 1);
    e = b_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("b_hold_valid", 32'(bus.SLAVE_WR_BACK_VALID), 1);
      check("b_hold_id", 32'(bus.SLAVE_WR_BACK_ID), 32'(e[5:2]));
      check("b_hold_resp", 32'(bus.SLAVE_WR_BACK_RESP), 32'(e[1:0]));
      tick();
    end
    bus.SLAVE_WR_BACK_READY = 1'b1;
    n = 0;
    while (bus.SLAVE_WR_BACK_VALID !== 1'b1 && n < 50) begin tick(); n++; end
    check("b_wait", 32'(n < 50), 1);
    check("b_id", 32'(bus.SLAVE_WR_BACK_ID), 32'(e[5:2]));
    check("b_resp", 32'(bus.SLAVE_WR_BACK_RESP), 32'(e[1:0]));
    tick();
    bus.SLAVE_WR_BACK_READY = 1'b0;
    check("aw_ready_after_b", 32'(bus.SLAVE_WR_ADDR_READY), 1);
  endtask

  // stop_after < beats leaves the burst in flight with RD_DATA_READY still high.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stop_after);
    int n;
    rd_exp_t e;
    bus.SLAVE_RD_ADDR_ID    = id;
    bus.SLAVE_RD_ADDR       = addr;
    bus.SLAVE_RD_ADDR_LEN   = len;
    bus.SLAVE_RD_ADDR_BURST = burst;
    bus.SLAVE_RD_ADDR_VALID = 1'b1;
    n = 0;
    while (bus.SLAVE_RD_ADDR_READY !== 1'b1 && n < 50) begin tick(); n++; end
    check("ar_wait", 32'(n < 50), 1);
    tick();
    bus.SLAVE_RD_ADDR_VALID = 1'b0;
    check("r_valid_after_ar", 32'(bus.SLAVE_RD_DATA_VALID), 1);
    check("ar_ready_busy", 32'(bus.SLAVE_RD_ADDR_READY), 0);
    bus.SLAVE_RD_DATA_READY = 1'b1;
    for (int i = 0; i <= int'(len) && i < stop_after; i++) begin
      n = 0;
      while (bus.SLAVE_RD_DATA_VALID !== 1'b1 && n < 50) begin tick(); n++; end
      check("r_wait", 32'(n < 50), 1);
      check("r_queue_nonempty", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("r_data", bus.SLAVE_RD_DATA, e.data);
        check("r_resp", 32'(bus.SLAVE_RD_DATA_RESP), 32'(e.resp));
        check("r_last", 32'(bus.SLAVE_RD_DATA_LAST), 32'(e.last));
        check("r_id", 32'(bus.SLAVE_RD_BACK_ID), 32'(id));
      end
      tick();
    end
    if (stop_after > int'(len)) begin
      bus.SLAVE_RD_DATA_READY = 1'b0;
      check("r_valid_done", 32'(bus.SLAVE_RD_DATA_VALID), 0);
      check("ar_ready_after_r", 32'(bus.SLAVE_RD_ADDR_READY), 1);
    end
  endtask

  initial begin
    bus.SLAVE_WR_ADDR_ID    = '0;
    bus.SLAVE_WR_ADDR       = '0;
    bus.SLAVE_WR_ADDR_LEN   = '0;
    bus.SLAVE_WR_ADDR_BURST = '0;
    bus.SLAVE_WR_ADDR_VALID = 1'b0;
    bus.SLAVE_WR_DATA       = '0;
    bus.SLAVE_WR_STRB       = '0;
    bus.SLAVE_WR_DATA_LAST  = 1'b0;
    bus.SLAVE_WR_DATA_VALID = 1'b0;
    bus.SLAVE_WR_BACK_READY = 1'b0;
    bus.SLAVE_RD_ADDR_ID    = '0;
    bus.SLAVE_RD_ADDR       = '0;
    bus.SLAVE_RD_ADDR_LEN   = '0;
    bus.SLAVE_RD_ADDR_BURST = '0;
    bus.SLAVE_RD_ADDR_VALID = 1'b0;
    bus.SLAVE_RD_DATA_READY = 1'b0;

    // Reset: everything low.
    SLAVE_RST = 1'b1;
    repeat (3) tick();
    check("rst_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 0);
    check("rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 0);
    check("rst_w_ready", 32'(bus.SLAVE_WR_DATA_READY), 0);
    check("rst_b_valid", 32'(bus.SLAVE_WR_BACK_VALID), 0);
    check("rst_r_valid", 32'(bus.SLAVE_RD_DATA_VALID), 0);
    check("rst_r_data", bus.SLAVE_RD_DATA, 0);
    check("rst_busy", 32'(busy_flag), 0);
    SLAVE_RST = 1'b0;
    tick();
    check("post_rst_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 1);
    check("post_rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 1);

    // INCR write/read.
    axi_write(4'd3, 32'h10, 8'd3, 2'b01, 32'hA0, 4'hF, 3, 2'b00, 0);
    push_seq(32'hA0, 4);
    axi_read(4'd3, 32'h10, 8'd3, 2'b01, 999);

    // Byte strobes.
    axi_write(4'd1, 32'h0, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF, 0, 2'b00, 0);
    axi_write(4'd1, 32'h0, 8'd0, 2'b01, 32'h1122_3344, 4'h5, 0, 2'b00, 0);
    push_rd(32'hFF22_FF44, 2'b00, 1'b1);
    axi_read(4'd2, 32'h0, 8'd0, 2'b01, 999);

    // WRAP burst over a preloaded window 0x30..0x3C.
    axi_write(4'd4, 32'h30, 8'd3, 2'b01, 32'hE0, 4'hF, 3, 2'b00, 0);
`ifdef SLAVE_RAM_WRAP_BURST_EN
    axi_write(4'd4, 32'h38, 8'd3, 2'b10, 32'hD0, 4'hF, 3, 2'b00, 0);
    push_rd(32'hD2, 2'b00, 1'b0);
    push_rd(32'hD3, 2'b00, 1'b0);
    push_rd(32'hD0, 2'b00, 1'b0);
    push_rd(32'hD1, 2'b00, 1'b1);
    axi_read(4'd4, 32'h30, 8'd3, 2'b01, 999);
    push_seq(32'hD0, 4);
    axi_read(4'd4, 32'h38, 8'd3, 2'b10, 999);
`else
    axi_write(4'd4, 32'h38, 8'd3, 2'b10, 32'hD0, 4'hF, 3, 2'b10, 0);
    push_seq(32'hE0, 4);
    axi_read(4'd4, 32'h30, 8'd3, 2'b01, 999);
    for (int i = 0; i < 4; i++) push_rd(32'h0, 2'b10, i == 3);
    axi_read(4'd4, 32'h38, 8'd3, 2'b10, 999);
`endif

    // Top of memory and one past it.
    axi_write(4'd8, 32'h3FC, 8'd0, 2'b01, 32'h5A5A_0000, 4'hF, 0, 2'b00, 0);
    push_rd(32'h5A5A_0000, 2'b00, 1'b0);
    push_rd(32'h0, 2'b11, 1'b1);
    axi_read(4'd8, 32'h3FC, 8'd1, 2'b01, 999);
    axi_write(4'd8, 32'h3FC, 8'd1, 2'b01, 32'hC0, 4'hF, 1, 2'b11, 0);
    push_rd(32'hC0, 2'b00, 1'b1);
    axi_read(4'd8, 32'h3FC, 8'd0, 2'b01, 999);

    // Early LAST: data still written, SLVERR, B held for 5 cycles.
    axi_write(4'd5, 32'h80, 8'd1, 2'b01, 32'hB0, 4'hF, 0, 2'b10, 5);
    push_seq(32'hB0, 2);
    axi_read(4'd5, 32'h80, 8'd1, 2'b01, 999);

    // Reset in the middle of an 8-beat read.
    axi_write(4'd6, 32'h40, 8'd7, 2'b01, 32'h70, 4'hF, 7, 2'b00, 0);
    push_seq(32'h70, 8);
    axi_read(4'd7, 32'h40, 8'd7, 2'b01, 2);
    check("mid_burst_r_valid", 32'(bus.SLAVE_RD_DATA_VALID), 1);
    SLAVE_RST = 1'b1;
    bus.SLAVE_RD_DATA_READY = 1'b0;
    tick();
    check("mid_rst_r_valid", 32'(bus.SLAVE_RD_DATA_VALID), 0);
    check("mid_rst_busy", 32'(busy_flag), 0);
    rd_q.delete();
    tick();
    SLAVE_RST = 1'b0;
    tick();
    check("after_rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 1);
    check("after_rst_r_valid", 32'(bus.SLAVE_RD_DATA_VALID), 0);
    push_seq(32'h70, 8);
    axi_read(4'd7, 32'h40, 8'd7, 2'b01, 999);
    check("scoreboard_drained", 32'(rd_q.size() + b_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/axi_slave_ram_responder.md
# axi_slave_ram_responder

Single-clock AXI4 slave endpoint that terminates the slave-side interface of the lab bus: accepts write/read address bursts, stores write data into an internal word RAM and returns read data and write responses. Sits on the SLAVE_CLK side of a slave clock-domain bridge, serving as a scratch/mailbox memory and as the reference responder for bus-level verification. Write and read paths are independent state machines sharing one memory array.

## Interface
- MEM_DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (byte address span = 4 << MEM_DEPTH_LOG2)
- SLAVE_CLK  in  1  sole clock, all logic on rising edge
- SLAVE_RST  in  1  reset, synchronous, active-high
- SLAVE_WR_ADDR_ID / SLAVE_WR_ADDR / SLAVE_WR_ADDR_LEN / SLAVE_WR_ADDR_BURST  in  4/32/8/2  write address channel payload
- SLAVE_WR_ADDR_VALID  in  1;  SLAVE_WR_ADDR_READY  out  1
- SLAVE_WR_DATA / SLAVE_WR_STRB / SLAVE_WR_DATA_LAST  in  32/4/1  write data payload
- SLAVE_WR_DATA_VALID  in  1;  SLAVE_WR_DATA_READY  out  1
- SLAVE_WR_BACK_ID / SLAVE_WR_BACK_RESP  out  4/2  write response payload
- SLAVE_WR_BACK_VALID  out  1;  SLAVE_WR_BACK_READY  in  1
- SLAVE_RD_ADDR_ID / SLAVE_RD_ADDR / SLAVE_RD_ADDR_LEN / SLAVE_RD_ADDR_BURST  in  4/32/8/2  read address payload
- SLAVE_RD_ADDR_VALID  in  1;  SLAVE_RD_ADDR_READY  out  1
- SLAVE_RD_BACK_ID / SLAVE_RD_DATA / SLAVE_RD_DATA_RESP / SLAVE_RD_DATA_LAST  out  4/32/2/1  read data payload
- SLAVE_RD_DATA_VALID  out  1;  SLAVE_RD_DATA_READY  in  1
- busy_flag  out  2  {write FSM not IDLE, read FSM not IDLE}

## Operation
- Handshake: transfer when VALID && READY on a rising edge; every outputted VALID holds with stable payload until accepted.
- Word index = ADDR[MEM_DEPTH_LOG2+1:2]; ADDR[1:0] ignored. Beat out of range (ADDR >= 4<<MEM_DEPTH_LOG2) -> DECERR (2'b11): write dropped, read data 0.
- Burst address step: FIXED (00) constant; INCR (01) +4 per beat, 32-bit modulo; WRAP (10) +4 within window of (LEN+1)*4 bytes aligned to that size, legal LEN 1/3/7/15 only; reserved (11) -> SLVERR (2'b10) all beats, no writes, read data 0.
- Write FSM: W_IDLE (WR_ADDR_READY=1) -> W_DATA on AW handshake, latch ID/addr/LEN/BURST, beat count 0. W_DATA (WR_DATA_READY=1): each beat writes bytes whose STRB bit is set; burst ends on beat LEN+1 regardless of LAST. LAST asserted on an earlier beat, or deasserted on beat LEN+1 -> SLVERR, data still written. -> W_RESP: BACK_VALID=1, BACK_ID=latched ID, RESP = worst seen (DECERR > SLVERR > OKAY); on BACK_READY -> W_IDLE.
- Read FSM: R_IDLE (RD_ADDR_READY=1) -> R_DATA on AR handshake. R_DATA: RD_DATA_VALID=1, DATA = combinational read of current word, per-beat RESP, LAST=1 on beat LEN+1, BACK_ID=latched ID; on accept advance address; after last beat -> R_IDLE.
- Same-cycle write and read of one word: read returns old contents; write visible the following cycle.
- Reset: FSMs to IDLE, counters/latches cleared, in-flight bursts discarded without response; RAM contents not cleared.

## Timing
- During reset all outputs 0 (all VALID/READY low, payloads 0, busy_flag 0). First cycle after reset deassert: WR_ADDR_READY=RD_ADDR_READY=1.
- AW handshake cycle N -> WR_DATA_READY high from N+1; last W beat at M -> BACK_VALID high at M+1; WR_ADDR_READY high again the cycle after B handshake.
- AR handshake N -> RD_DATA_VALID high at N+1; with READY held high, one beat per cycle, LEN+1 beats in cycles N+1..N+LEN+1; RD_ADDR_READY high the cycle after last beat.
- Only one burst outstanding per direction; ADDR_READY low while busy. Read and write proceed concurrently.
- LEN=0 is a single beat; LEN=255 yields 256 beats, 9-bit beat counter.

## Configuration
- SLAVE_RAM_WRAP_BURST_EN defined: WRAP bursts executed as above (illegal LEN -> SLVERR).
- Undefined: BURST=2'b10 treated as reserved -> SLVERR for every beat, no writes, read data 0, beat count and LAST timing unchanged.

## Test plan
- INCR write ID=3, ADDR=0x10, LEN=3, data 0xA0..0xA3, STRB=0xF -> BACK RESP=00 ID=3; INCR read same -> 0xA0,0xA1,0xA2,0xA3, LAST only on 4th, VALID N+1.
- Write 0x11223344 STRB=0x5 over 0xFFFFFFFF at 0x0 -> readback 0xFF22FF44.
- WRAP ADDR=0x38, LEN=3 (macro on) -> words 0x38,0x3C,0x30,0x34; macro off -> RESP=10 each beat, data 0.
- Read ADDR=0x3FC LEN=1, depth 256 -> beat0 OKAY, beat1 (0x400) DECERR data 0; write same -> RESP=11.
- Write LEN=1 with LAST on beat 0 -> both beats written, RESP=10; BACK_READY held low 5 cycles -> BACK_VALID/ID/RESP stable.
- Assert SLAVE_RST mid read burst LEN=7 after 2 beats -> VALID 0 next cycle, no further beats; RD_ADDR_READY=1 after release, RAM data intact.
